// File: rtl/axi_lite_read_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite read arbiter.
// The write-side arbiter reuses the response encodings.
package ArbConsts;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, TIMEOUT, DRAIN} ArbState;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_read_arbiter_if.sv
// AXI4-Lite read channel bundle (AR + R).
// The master modport issues addresses and sinks data; the slave modport is the opposite side.
interface axi_lite_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_read_arbiter_rr_grant2.sv
// Combinational two-way round-robin pick.
// On a tie, the port that did not win last time is chosen.
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       grant_valid
);

  assign grant_valid = |req;
  assign grant       = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// Shares one AXI4-Lite read port between instruction fetch (port 0) and loads (port 1).
// It keeps one transaction in flight, and a watchdog answers SLVERR if the slave stalls read data.
module axi_lite_read_arbiter
  import ArbConsts::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_lite_read_arbiter_if.slave  s0_bus,
  axi_lite_read_arbiter_if.slave  s1_bus,
  axi_lite_read_arbiter_if.master m_bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ArbState           state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              got_late_q, got_late_d;

  logic              rr_grant, rr_valid;
  logic [1:0]        s_arready, s_rvalid, s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              m_arvalid, m_rready;

  rr_grant2 u_rr_grant2 (
    .req         ({s1_bus.arvalid, s0_bus.arvalid}),
    .last        (last_grant_q),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  assign s_rready = {s1_bus.rready, s0_bus.rready};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      m_araddr_q   <= '0;
      cnt_q        <= '0;
      got_late_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_araddr_q   <= m_araddr_d;
      cnt_q        <= cnt_d;
      got_late_q   <= got_late_d;
    end
  end

  // last_grant_q doubles as the owner of the outstanding transaction.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_araddr_d   = m_araddr_q;
    cnt_d        = cnt_q;
    got_late_d   = got_late_q;
    s_arready    = '0;
    s_rvalid     = '0;
    s_rdata      = '0;
    s_rresp      = RESP_OKAY;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        got_late_d = 1'b0;
        if (rr_valid) begin
          s_arready[rr_grant] = 1'b1;
          m_araddr_d          = rr_grant ? s1_bus.araddr : s0_bus.araddr;
          last_grant_d        = rr_grant;
          state_d             = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_bus.arready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        m_rready               = s_rready[last_grant_q];
        s_rvalid[last_grant_q] = m_bus.rvalid;
        s_rdata                = m_bus.rdata;
        s_rresp                = m_bus.rresp;
        if (m_bus.rvalid && s_rready[last_grant_q]) begin
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && !m_bus.rvalid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = TIMEOUT;
        end
      end
      TIMEOUT: begin
        // Keep absorbing so a late beat cannot wedge the slave.
        m_rready               = 1'b1;
        s_rvalid[last_grant_q] = 1'b1;
        s_rresp                = RESP_SLVERR;
        if (m_bus.rvalid) got_late_d = 1'b1;
        if (s_rready[last_grant_q]) state_d = (got_late_q || m_bus.rvalid) ? IDLE : DRAIN;
      end
      DRAIN: begin
        m_rready = 1'b1;
        if (m_bus.rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s0_bus.arready = s_arready[0];
  assign s1_bus.arready = s_arready[1];
  assign s0_bus.rvalid  = s_rvalid[0];
  assign s1_bus.rvalid  = s_rvalid[1];
  assign s0_bus.rdata   = (last_grant_q == 1'b0) ? s_rdata : '0;
  assign s1_bus.rdata   = (last_grant_q == 1'b1) ? s_rdata : '0;
  assign s0_bus.rresp   = (last_grant_q == 1'b0) ? s_rresp : RESP_OKAY;
  assign s1_bus.rresp   = (last_grant_q == 1'b1) ? s_rresp : RESP_OKAY;

  assign m_bus.araddr  = m_araddr_q;
  assign m_bus.arvalid = m_arvalid;
  assign m_bus.rready  = m_rready;

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Directed self-checking bench for axi_lite_read_arbiter with a short watchdog (8 cycles).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_axi_lite_read_arbiter;
  import ArbConsts::*;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  axi_lite_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  axi_lite_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
  axi_lite_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  axi_lite_read_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s0_bus (s0_if),
    .s1_bus (s1_if),
    .m_bus  (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 200000ns");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic a0v, input logic [31:0] a0, input logic a1v,
                               input logic [31:0] a1, input logic mar, input logic mrv,
                               input logic [31:0] mrd, input logic [1:0] mrr,
                               input logic rr0, input logic rr1);
    s0_if.arvalid = a0v;
    s0_if.araddr  = a0;
    s1_if.arvalid = a1v;
    s1_if.araddr  = a1;
    m_if.arready  = mar;
    m_if.rvalid   = mrv;
    m_if.rdata    = mrd;
    m_if.rresp    = mrr;
    s0_if.rready  = rr0;
    s1_if.rready  = rr1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic ownArready(input logic p);
    return p ? s1_if.arready : s0_if.arready;
  endfunction

  function automatic logic ownRvalid(input logic p);
    return p ? s1_if.rvalid : s0_if.rvalid;
  endfunction

  function automatic logic [31:0] ownRdata(input logic p);
    return p ? s1_if.rdata : s0_if.rdata;
  endfunction

  function automatic logic [1:0] ownRresp(input logic p);
    return p ? s1_if.rresp : s0_if.rresp;
  endfunction

  // One request from a single port against a zero-wait slave; leaves the arbiter in IDLE.
  task automatic zeroWaitRead(input logic p, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(!p, addr, p, addr, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("zw_arready_own", ownArready(p), 1'b1);
    checkOutput("zw_arready_other", ownArready(!p), 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("zw_arvalid", m_if.arvalid, 1'b1);
    checkOutput("zw_araddr", m_if.araddr, addr);
    checkOutput("zw_arready_idle", ownArready(!p), 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, data, RESP_OKAY, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("zw_rvalid_own", ownRvalid(p), 1'b1);
    checkOutput("zw_rdata", ownRdata(p), data);
    checkOutput("zw_rresp", ownRresp(p), RESP_OKAY);
    checkOutput("zw_rvalid_other", ownRvalid(!p), 1'b0);
    checkOutput("zw_rready", m_if.rready, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("zw_rvalid_done", ownRvalid(p), 1'b0);
    checkOutput("zw_arvalid_done", m_if.arvalid, 1'b0);
    nextCycle();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #3;
    checkOutput("rst_arvalid", m_if.arvalid, 1'b0);
    checkOutput("rst_araddr", m_if.araddr, 32'h0);
    checkOutput("rst_rready", m_if.rready, 1'b0);
    checkOutput("rst_rvalid0", s0_if.rvalid, 1'b0);
    checkOutput("rst_rvalid1", s1_if.rvalid, 1'b0);

    $display("[TB] single port 0 read");
    applyReset();
    zeroWaitRead(1'b0, 32'h0000_0100, 32'hCAFE_0001);

    $display("[TB] both ports requesting every cycle");
    applyReset();
    for (int k = 0; k < 4; k++) begin
      logic        expPort;
      logic [31:0] expAddr;
      logic [31:0] beat;
      expPort = (k % 2 == 1);
      expAddr = expPort ? 32'h0000_4000 : 32'h0000_0000;
      beat    = 32'hD0D0_0000 + 32'(k);
      applyStimulus(1'b1, 32'h0, 1'b1, 32'h4000, 1'b1, 1'b1, beat, RESP_OKAY, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("alt_arready_own", ownArready(expPort), 1'b1);
      checkOutput("alt_arready_other", ownArready(!expPort), 1'b0);
      nextCycle();
      @(negedge clk);
      checkOutput("alt_araddr", m_if.araddr, expAddr);
      checkOutput("alt_no_arready", {31'h0, s0_if.arready | s1_if.arready}, 32'h0);
      nextCycle();
      @(negedge clk);
      checkOutput("alt_rvalid_own", ownRvalid(expPort), 1'b1);
      checkOutput("alt_rdata", ownRdata(expPort), beat);
      checkOutput("alt_rvalid_other", ownRvalid(!expPort), 1'b0);
      nextCycle();
    end

    $display("[TB] slave stalls address phase");
    applyReset();
    applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("stall_arready", s0_if.arready, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("stall_arvalid", m_if.arvalid, 1'b1);
      checkOutput("stall_araddr", m_if.araddr, 32'h200);
      checkOutput("stall_no_err", s0_if.rvalid, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1357_2468, RESP_OKAY, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("stall_rdata", s0_if.rdata, 32'h1357_2468);
    checkOutput("stall_rresp", s0_if.rresp, RESP_OKAY);
    nextCycle();

    $display("[TB] watchdog timeout and drain");
    applyReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("to_arready", s1_if.arready, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("to_wait_rvalid", s1_if.rvalid, 1'b0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("to_rvalid", s1_if.rvalid, 1'b1);
    checkOutput("to_rresp", s1_if.rresp, RESP_SLVERR);
    checkOutput("to_rdata", s1_if.rdata, 32'h0);
    checkOutput("to_rready", m_if.rready, 1'b1);
    checkOutput("to_other_rvalid", s0_if.rvalid, 1'b0);
    nextCycle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("drain_rready", m_if.rready, 1'b1);
      checkOutput("drain_rvalid", s1_if.rvalid, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, RESP_OKAY, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("late_rready", m_if.rready, 1'b1);
    checkOutput("late_rvalid", s1_if.rvalid, 1'b0);
    nextCycle();
    zeroWaitRead(1'b0, 32'h0000_0400, 32'h0000_4444);

    $display("[TB] requester back-pressure");
    applyReset();
    applyStimulus(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA, RESP_OKAY, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("bp_rready", m_if.rready, 1'b0);
      checkOutput("bp_rvalid", s0_if.rvalid, 1'b1);
      checkOutput("bp_rdata", s0_if.rdata, 32'h5555_AAAA);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA, RESP_OKAY, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_handshake", m_if.rready, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_idle_rvalid", s0_if.rvalid, 1'b0);
    checkOutput("bp_idle_rready", m_if.rready, 1'b0);
    nextCycle();

    $display("[TB] reset during data phase");
    applyReset();
    applyStimulus(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("mid_rready", m_if.rready, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rready", m_if.rready, 1'b0);
    checkOutput("mid_rst_arvalid", m_if.arvalid, 1'b0);
    checkOutput("mid_rst_araddr", m_if.araddr, 32'h0);
    checkOutput("mid_rst_rvalid", s0_if.rvalid, 1'b0);
    #2;
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 32'h700, 1'b1, 32'h800, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("post_rst_tie0", s0_if.arready, 1'b1);
    checkOutput("post_rst_tie1", s1_if.arready, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("post_rst_araddr", m_if.araddr, 32'h700);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
